// File: rtl/interval_timer_arbiter_pkg.sv
// Shared types and defaults for the interval timer arbiter.
package itm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } itm_state_e;

   localparam int unsigned ITM_NUM_REQ = 4;
   localparam int unsigned ITM_WIDTH   = 4;

endpackage

// File: rtl/interval_timer_arbiter_counter.sv
// Loadable up counter owned by the arbiter; priority rst > load > en.
module interval_up_counter
   import itm_pkg::*;
#(
   parameter int unsigned WIDTH = ITM_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_out <= '0;
      end else if (load) begin
         data_out <= data_in;
      end else if (en) begin
         data_out <= data_out + 1'b1;
      end
   end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter sharing one interval counter among NUM_REQ requesters.
module interval_timer_arbiter
   import itm_pkg::*;
#(
   parameter int unsigned NUM_REQ = ITM_NUM_REQ,
   parameter int unsigned WIDTH   = ITM_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] interval,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic [WIDTH-1:0]         count
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   itm_state_e         state, state_next;
   logic [IDX_W-1:0]   idx, idx_next;
   logic [IDX_W-1:0]   ptr, ptr_next;
   logic [IDX_W-1:0]   cand, pick;
   logic               found;
   logic [NUM_REQ-1:0] grant_next, done_next;
   logic               cnt_load, cnt_en;
   logic [WIDTH-1:0]   load_value;

   assign load_value = ~interval[idx*WIDTH +: WIDTH];
   assign busy       = (state != IDLE);

   interval_up_counter #(.WIDTH(WIDTH)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .en       (cnt_en),
      .data_in  (load_value),
      .data_out (count)
   );

   // Scan starts just past the last owner so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      ptr_next   = ptr;
      grant_next = grant;
      done_next  = '0;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_next       = LOAD;
               idx_next         = pick;
               ptr_next         = pick;
               grant_next       = '0;
               grant_next[pick] = 1'b1;
            end
         end
         LOAD: begin
            cnt_load   = 1'b1;
            state_next = COUNT;
         end
         COUNT: begin
            // Abort outranks expiry: a dropped request never sees done.
            if (!req[idx]) begin
               state_next = IDLE;
               grant_next = '0;
            end else if (&count) begin
               state_next     = DONE;
               done_next[idx] = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
            grant_next = '0;
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         idx   <= '0;
         ptr   <= LAST_IDX;
         grant <= '0;
         done  <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         ptr   <= ptr_next;
         grant <= grant_next;
         done  <= done_next;
      end
   end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Self-checking bench: table of transactions plus hand sequences, scored per cycle.
module tb_interval_timer_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] interval;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic [3:0]  count;

   interval_timer_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .interval (interval),
      .grant    (grant),
      .done     (done),
      .busy     (busy),
      .count    (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] ivals;
      int unsigned idx;
      int unsigned drop;
   } vec_t;

   typedef struct {
      logic [3:0] grant;
      logic [3:0] done;
      logic       busy;
      logic [3:0] count;
   } exp_t;

   vec_t        tbl [10];
   exp_t        sb [$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [3:0]  model_count;

   task automatic check(input string name, input int unsigned cyc,
                        input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] g, input logic [3:0] d, input logic b,
                       input logic [3:0] c);
      exp_t e;
      e.grant = g;
      e.done  = d;
      e.busy  = b;
      e.count = c;
      sb.push_back(e);
   endtask

   // Expected per-cycle trace from the documented timing of one grant.
   task automatic push_trace(input int unsigned idx, input int unsigned n,
                             input int unsigned drop, output int unsigned len);
      logic [3:0] oh;
      logic [3:0] nv;
      logic [3:0] c;
      oh = 4'b0001 << idx;
      nv = n[3:0];
      push(oh, 4'b0000, 1'b1, model_count);
      for (int unsigned k = 2; k <= 2 + n; k++) begin
         c = (~nv) + 4'(k - 2);
         push(oh, 4'b0000, 1'b1, c);
         if (drop != 0 && k == drop) begin
            push(4'b0000, 4'b0000, 1'b0, c);
            model_count = c;
            len = drop + 1;
            return;
         end
      end
      push(oh, oh, 1'b1, 4'hF);
      push(4'b0000, 4'b0000, 1'b0, 4'hF);
      model_count = 4'hF;
      len = n + 4;
   endtask

   // Caller is #1 after an edge with req already driven.
   task automatic play(input int unsigned len, input bit scramble,
                       input int unsigned drop_c, input int unsigned rst_c);
      exp_t e;
      @(posedge clk);
      #1;
      for (int unsigned c = 1; c <= len; c++) begin
         if (c == drop_c) req = 4'b0000;
         if (sb.size() == 0) begin
            check("scoreboard_empty", c, 8'd1, 8'd0);
         end else begin
            e = sb.pop_front();
            check("grant", c, {4'b0, grant}, {4'b0, e.grant});
            check("done",  c, {4'b0, done},  {4'b0, e.done});
            check("busy",  c, {7'b0, busy},  {7'b0, e.busy});
            check("count", c, {4'b0, count}, {4'b0, e.count});
         end
         if (scramble && c == 2) interval = 16'($urandom);
         if (c == rst_c) rst = 1'b0;
         if (rst_c != 0 && c == rst_c + 1) rst = 1'b1;
         if (c == len) req = 4'b0000;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int unsigned len, l2, l3;
      tbl[0] = '{4'b0001, 16'h0003, 0, 0};
      tbl[1] = '{4'b0010, 16'h0000, 1, 0};
      tbl[2] = '{4'b0100, 16'h0800, 2, 5};
      tbl[3] = '{4'b1111, 16'h2111, 3, 0};
      tbl[4] = '{4'b1111, 16'h2111, 0, 0};
      tbl[5] = '{4'b0101, 16'h0400, 2, 0};
      tbl[6] = '{4'b1000, 16'hF000, 3, 0};
      tbl[7] = '{4'b1000, 16'hF000, 3, 0};
      tbl[8] = '{4'b1001, 16'h0005, 0, 0};
      tbl[9] = '{4'b0110, 16'h0060, 1, 0};

      rst = 1'b0;
      req = 4'b0000;
      interval = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_grant", 0, {4'b0, grant}, 8'h00);
      check("reset_done",  0, {4'b0, done},  8'h00);
      check("reset_busy",  0, {7'b0, busy},  8'h00);
      check("reset_count", 0, {4'b0, count}, 8'h00);
      rst = 1'b1;
      model_count = 4'h0;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         req      = tbl[i].req;
         interval = tbl[i].ivals;
         push_trace(tbl[i].idx, 32'(tbl[i].ivals[tbl[i].idx*4 +: 4]), tbl[i].drop, len);
         play(len, 1'b1, tbl[i].drop, 0);
      end

      // Reset asserted during cycle 4 of a count, then a fresh grant.
      req = 4'b0100;
      interval = 16'h0800;
      push(4'b0100, 4'b0000, 1'b1, model_count);
      push(4'b0100, 4'b0000, 1'b1, 4'h7);
      push(4'b0100, 4'b0000, 1'b1, 4'h8);
      push(4'b0100, 4'b0000, 1'b1, 4'h9);
      push(4'b0000, 4'b0000, 1'b0, 4'h0);
      play(5, 1'b0, 0, 4);
      model_count = 4'h0;
      req = 4'b1000;
      interval = 16'h2000;
      push_trace(3, 2, 0, len);
      play(len, 1'b0, 0, 0);

      // Two requesters held: grants alternate with one idle cycle between.
      req = 4'b0011;
      interval = 16'h0011;
      push_trace(0, 1, 0, len);
      push_trace(1, 1, 0, l2);
      push_trace(0, 1, 0, l3);
      play(len + l2 + l3, 1'b0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("idle_grant", 0, {4'b0, grant}, 8'h00);
      check("idle_busy",  0, {7'b0, busy},  8'h00);
      check("sb_leftover", 0, 8'(sb.size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
